// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bus between the multicycle FSM and the datapath
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_op, state
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_op, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I main control FSM
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_illegal_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                w_next       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute branch target PC+imm into ALUOut
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECUTER;
                    7'b0010011:             w_next = S_EXECUTEI;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100011:             w_next = S_BRANCH;
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_next      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BRANCH: begin
                // funct3[0] inverts the sense so one path serves beq and bne
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_pc_write  = bus.zero ^ bus.funct3[0];
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            7'b0100011: bus.imm_src = 2'b01;
            7'b1100011: bus.imm_src = 2'b10;
            7'b1101111: bus.imm_src = 2'b11;
            default:    bus.imm_src = 2'b00;
        endcase
    end

    // Enables are forced low while reset is held; state is already FETCH so selects follow
    assign bus.pc_write   = rst_n & w_pc_write;
    assign bus.ir_write   = rst_n & w_ir_write;
    assign bus.mem_write  = rst_n & w_mem_write;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.illegal_op = rst_n & w_illegal_op;
    assign bus.adr_src    = w_adr_src;
    assign bus.result_src = w_result_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // exp = {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_op}
    typedef struct packed {
        logic        mr;
        logic        z;
        logic [2:0]  f3;
        logic [6:0]  op;
        logic [19:0] exp;
    } step_t;

    step_t sb_q[$];
    step_t s;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic mr, input logic z, input logic [2:0] f3, input logic [6:0] op,
                                 input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
                                 input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                 input logic [1:0] sbv, input logic [1:0] ao, input logic [1:0] imm,
                                 input logic rw, input logic ill);
        step_t t;
        t.mr  = mr;
        t.z   = z;
        t.f3  = f3;
        t.op  = op;
        t.exp = {st, pcw, adr, mw, irw, rs, sa, sbv, ao, imm, rw, ill};
        sb_q.push_back(t);
    endfunction

    function automatic logic [19:0] obs();
        return {bus.state, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src, bus.reg_write, bus.illegal_op};
    endfunction

    task automatic drive(input step_t t);
        bus.mem_ready = t.mr;
        bus.zero      = t.z;
        bus.funct3    = t.f3;
        bus.op        = t.op;
    endtask

    task automatic test_reset();
        bus.op = 7'b0; bus.funct3 = 3'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold: got %h want %h", obs(), {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00});
        end
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release_stall: got %h want %h", obs(), {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00});
        end
        @(negedge clk);
    endtask

    task automatic test_alu();
        push(1, 0, 3'b000, OP_R, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b000, OP_R, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b000, OP_R, 4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
        push(1, 0, 3'b000, OP_R, 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        push(1, 0, 3'b000, OP_I, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b000, OP_I, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b000, OP_I, 4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0);
        push(1, 0, 3'b000, OP_I, 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            drive(s);
            #1;
            checks++;
            if (obs() !== s.exp) begin
                failures++;
                $display("FAIL alu_step op=%b: got %h want %h", s.op, obs(), s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_stall();
        push(0, 0, 3'b010, OP_LW, 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b010, OP_LW, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b010, OP_LW, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b010, OP_LW, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
        push(0, 0, 3'b010, OP_LW, 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        push(0, 0, 3'b010, OP_LW, 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b010, OP_LW, 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b010, OP_LW, 4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            drive(s);
            #1;
            checks++;
            if (obs() !== s.exp) begin
                failures++;
                $display("FAIL lw_step mr=%b: got %h want %h", s.mr, obs(), s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_jal();
        push(1, 0, 3'b010, OP_SW,  4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW,  4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW,  4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW,  4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b000, OP_JAL, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 0, 0);
        push(1, 0, 3'b000, OP_JAL, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0);
        push(1, 0, 3'b000, OP_JAL, 4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0);
        push(1, 0, 3'b000, OP_JAL, 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            drive(s);
            #1;
            checks++;
            if (obs() !== s.exp) begin
                failures++;
                $display("FAIL sw_jal_step op=%b: got %h want %h", s.op, obs(), s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b000};
        logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
        logic       tk  [3] = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            push(1, zs[k], f3s[k], OP_BR, 4'd0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
            push(1, zs[k], f3s[k], OP_BR, 4'd1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0);
            push(1, zs[k], f3s[k], OP_BR, 4'd10, tk[k], 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0, 0);
        end
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            drive(s);
            #1;
            checks++;
            if (obs() !== s.exp) begin
                failures++;
                $display("FAIL branch_step f3=%b zero=%b: got %h want %h", s.f3, s.z, obs(), s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        push(1, 0, 3'b000, OP_BAD, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        push(1, 0, 3'b000, OP_BAD, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 1);
        push(0, 0, 3'b000, OP_BAD, 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            drive(s);
            #1;
            checks++;
            if (obs() !== s.exp) begin
                failures++;
                $display("FAIL illegal_step: got %h want %h", obs(), s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midwrite();
        push(1, 0, 3'b010, OP_SW, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0);
        push(0, 0, 3'b010, OP_SW, 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
        push(0, 0, 3'b010, OP_SW, 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            drive(s);
            #1;
            checks++;
            if (obs() !== s.exp) begin
                failures++;
                $display("FAIL midwrite_step: got %h want %h", obs(), s.exp);
            end
            @(negedge clk);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_midwrite: got %h want %h", obs(), {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00});
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1, 0, 3'b010, OP_SW, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0);
        push(1, 0, 3'b010, OP_SW, 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
        push(0, 0, 3'b000, OP_R,  4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            drive(s);
            #1;
            checks++;
            if (obs() !== s.exp) begin
                failures++;
                $display("FAIL resume_step: got %h want %h", obs(), s.exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.op = 7'b0; bus.funct3 = 3'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_alu();
        test_lw_stall();
        test_sw_jal();
        test_branch();
        test_illegal();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I control path. Decodes the latched instruction's opcode over several cycles and drives the datapath enables, mux selects and the 2-bit `ALUOp` consumed by the ALU decoder. It is the driving end of the `ALUOp`/`opb5` interface. Memory accesses (fetch, load, store) stall on a `mem_ready` handshake.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: opcode from instruction register (stable outside FETCH).
- `funct3` in 3: instruction bits [14:12], used for branch sense.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: IR/OldPC enable.
- `result_src` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `alu_src_a` out 2: 00 PC, 01 OldPC, 10 rs1.
- `alu_src_b` out 2: 00 rs2, 01 ImmExt, 10 constant 4.
- `alu_op` out 2: to ALU decoder; 00 add, 01 sub/compare, 10 funct-decoded.
- `imm_src` out 2: 00 I, 01 S, 10 B, 11 J.
- `reg_write` out 1: register-file write enable.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10. Codes 11–15 are unreachable and return to FETCH.
- Unless listed, every enable is 0 and every select is 00.
- **FETCH**: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_op=00.
  - ir_write and pc_write equal mem_ready.
  - Go to DECODE when mem_ready=1, else stay.
- **DECODE**: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target). Next state by op:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1101111 → JAL.
  - 1100011 → BRANCH.
  - Any other op → FETCH, with illegal_op=1 for that cycle.
- **MEMADR**: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMWRITE if op[5]=1, else MEMREAD.
- **MEMREAD**: adr_src=1, result_src=00. Go to MEMWB when mem_ready=1, else hold.
- **MEMWB**: result_src=01, reg_write=1 → FETCH.
- **MEMWRITE**: adr_src=1, result_src=00, mem_write=1 held until mem_ready=1, then → FETCH.
- **EXECUTER**: alu_src_a=10, alu_src_b=00, alu_op=10 → ALUWB.
- **EXECUTEI**: alu_src_a=10, alu_src_b=01, alu_op=10 → ALUWB.
- **ALUWB**: result_src=00, reg_write=1 → FETCH.
- **JAL**: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 → ALUWB.
- **BRANCH**: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0], so beq and bne are both handled.
  - → FETCH.
- imm_src is a pure function of op:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - All other op → 00.

## Timing
- Registered state only. All outputs are combinational from state and op.
- Mealy exceptions: FETCH ir_write/pc_write depend on mem_ready; BRANCH pc_write depends on zero/funct3.
- Cycle counts with mem_ready=1 throughout:
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - jal: 4 cycles.
  - branch: 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- In those three states, outputs are identical on every stalled cycle.
- Reset:
  - rst_n=0 forces state=FETCH immediately.
  - While reset is asserted, pc_write, ir_write, mem_write, reg_write and illegal_op are all 0; selects hold their FETCH values.
  - A reset mid-instruction aborts it with no further writes.
  - The first edge after rst_n rises evaluates FETCH normally.
- alu_op is never driven to 11.

## Test plan
- **Reset**: rst_n=0 asynchronously in MEMWRITE with mem_ready=0 → state=0 and mem_write=0 within the same cycle; after release, fetch resumes.
- **R-type add**: op=0110011, mem_ready=1 → state sequence 0,1,6,7,0; alu_op=10 in state 6; reg_write=1 only in state 7.
- **lw with 2-cycle memory wait**: mem_ready=0 for 2 cycles in MEMREAD → state sequence 0,1,2,3,3,3,4,0; result_src=01 in state 4.
- **sw**: op=0100011 → imm_src=01 and mem_write=1 only in state 5.
- **Branch**:
  - beq (funct3=000) with zero=1 → pc_write=1 in state 10.
  - bne (funct3=001) with zero=1 → pc_write=0.
  - alu_op=01 in both cases.
- **Illegal opcode**: op=1111111 → illegal_op pulses for one cycle in DECODE, then state=0; no reg_write or mem_write asserted.
